// File: rtl/key_pkg.sv
// Shared types and elaboration-time helpers for the key scanner.
// Holds the per-key FSM state encoding, the tick divider derivation
// and the counter width derivation used by key_scan4 and key_debounce_fsm.
package key_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    LONG_HELD,
    RELEASE_WAIT
  } key_state_e;

  // Clocks per debounce tick.
  function automatic int tickDiv(input int clkHz, input int tickHz);
    return clkHz / tickHz;
  endfunction

  // Width large enough to hold the larger of the two tick thresholds.
  function automatic int cntWidth(input int debTicks, input int longTicks);
    int m;
    m = (debTicks > longTicks) ? debTicks : longTicks;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_debounce_fsm.sv
// One key: two-flop synchroniser, debounce/long-press FSM and its counters.
// Ports:
//   clk       system clock
//   nrst      asynchronous active-low reset
//   key_n_i   raw active-low key pin
//   tick_i    one-clk debounce tick shared by all keys
//   level_o   debounced level, 1 = pressed
//   press_o   one-clk pulse on accepted press
//   release_o one-clk pulse on accepted release
//   long_o    one-clk pulse once per press after the long-hold time
module key_debounce_fsm
  import key_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 20,
  parameter int LONG_TICKS     = 1000
) (
  input  logic clk,
  input  logic nrst,
  input  logic key_n_i,
  input  logic tick_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int CW = cntWidth(DEBOUNCE_TICKS, LONG_TICKS);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS);

  logic sync1_q, sync2_q;
  logic ksync;

  key_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cntInc;
  logic [CW-1:0] hold_q, hold_d, holdInc;
  logic longDone_q, longDone_d;
  logic level_q, level_d;
  logic press_q, press_d;
  logic release_q, release_d;
  logic long_q, long_d;

  // Synchroniser resets to "released" so leaving reset never looks like a press.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
    end
  end

  assign ksync   = ~sync2_q;
  assign cntInc  = cnt_q + CW'(1);
  assign holdInc = hold_q + CW'(1);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hold_q     <= '0;
      longDone_q <= 1'b0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      longDone_q <= longDone_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
    end
  end

  // A change of the synchronised level aborts a wait on any clock; ticks
  // only advance the counters. Returning from RELEASE_WAIT keeps the hold
  // count so a glitch neither restarts nor repeats the long-press timing.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    longDone_d = longDone_q;
    unique case (state_q)
      IDLE: begin
        if (ksync) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!ksync) begin
          state_d = IDLE;
        end else if (tick_i) begin
          cnt_d = cntInc;
          if (cntInc == DEB_LAST) begin
            state_d = PRESSED;
            hold_d  = '0;
          end
        end
      end
      PRESSED: begin
        if (!ksync) begin
          state_d    = RELEASE_WAIT;
          cnt_d      = '0;
          longDone_d = 1'b0;
        end else if (tick_i && (hold_q != LONG_LAST)) begin
          hold_d = holdInc;
          if (holdInc == LONG_LAST) begin
            state_d = LONG_HELD;
          end
        end
      end
      LONG_HELD: begin
        if (!ksync) begin
          state_d    = RELEASE_WAIT;
          cnt_d      = '0;
          longDone_d = 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (ksync) begin
          state_d = longDone_q ? LONG_HELD : PRESSED;
        end else if (tick_i) begin
          cnt_d = cntInc;
          if (cntInc == DEB_LAST) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Events are decoded from the transition being taken, then registered.
  always_comb begin
    level_d   = state_d inside {PRESSED, LONG_HELD, RELEASE_WAIT};
    press_d   = (state_q == PRESS_WAIT)   && (state_d == PRESSED);
    release_d = (state_q == RELEASE_WAIT) && (state_d == IDLE);
    long_d    = (state_q == PRESSED)      && (state_d == LONG_HELD);
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/key_scan4.sv
// Debounced push-button scanner for the board's active-low keys.
// Ports:
//   clk          system clock
//   nrst         asynchronous active-low reset
//   key_n        raw key pins, 0 = pressed
//   key_level    debounced level per key, 1 = pressed
//   key_press    one-clk press pulse per key
//   key_release  one-clk release pulse per key
//   key_long     one-clk long-press pulse per key
//   tick         one-clk pulse every TICK_DIV clocks
module key_scan4
  import key_pkg::*;
#(
  parameter int N_KEYS         = 4,
  parameter int CLK_HZ         = 50000000,
  parameter int TICK_HZ        = 1000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int LONG_TICKS     = 1000
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic              tick
);

  localparam int TICK_DIV = tickDiv(CLK_HZ, TICK_HZ);
  localparam int TW       = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] tickCnt_q, tickCnt_d;

  // tick is decoded from the counter's last value, so the first one lands
  // in the TICK_DIV-th cycle after reset release.
  assign tick      = (tickCnt_q == TICK_LAST);
  assign tickCnt_d = tick ? '0 : tickCnt_q + TW'(1);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tickCnt_q <= '0;
    end else begin
      tickCnt_q <= tickCnt_d;
    end
  end

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_debounce_fsm #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .LONG_TICKS    (LONG_TICKS)
    ) u_key (
      .clk      (clk),
      .nrst     (nrst),
      .key_n_i  (key_n[k]),
      .tick_i   (tick),
      .level_o  (key_level[k]),
      .press_o  (key_press[k]),
      .release_o(key_release[k]),
      .long_o   (key_long[k])
    );
  end

endmodule

// File: doc/key_scan4.md
Name: key_scan4

Overview:
- Input-side counterpart to the board LED drivers: reads the board's active-low push buttons (key_n).
- Synchronises each key and debounces it against a shared millisecond-scale tick.
- Emits a clean level plus one-cycle press, release and long-press event pulses per key.
- Sits between the board key pins and the user logic, e.g. pattern/speed selection for the LED chaser.

Parameters:
- N_KEYS, 4, number of independent keys.
- CLK_HZ, 50000000, clk frequency in Hz.
- TICK_HZ, 1000, debounce tick rate; TICK_DIV = CLK_HZ/TICK_HZ, must be >= 2.
- DEBOUNCE_TICKS, 20, consecutive stable ticks needed to accept a press or release (>= 1).
- LONG_TICKS, 1000, ticks in PRESSED (counted from the press pulse) before key_long fires (> DEBOUNCE_TICKS).

Ports:
- clk  input  1  system clock.
- nrst  input  1  reset, asynchronous, active-low.
- key_n  input  N_KEYS  raw button pins, asynchronous, 0 = pressed.
- key_level  output  N_KEYS  debounced state, 1 = pressed.
- key_press  output  N_KEYS  one-clk pulse on accepted press.
- key_release  output  N_KEYS  one-clk pulse on accepted release.
- key_long  output  N_KEYS  one-clk pulse once per press after LONG_TICKS held.
- tick  output  1  one-clk pulse every TICK_DIV clocks (for reuse/debug).

Behaviour:
- Reset (nrst=0, async): every output 0, tick counter 0, all key FSMs in IDLE, per-key counters 0.
  - Synchroniser flops reset to 1 (released), so no spurious press is generated.
- Synchroniser: two flops per key; ksync = ~key_n after 2 clk of latency.
- Tick generator:
  - Counter runs 0..TICK_DIV-1 and wraps.
  - tick=1 for exactly the cycle in which the counter equals TICK_DIV-1.
  - First tick occurs TICK_DIV clocks after reset release.
- Per-key FSM, states IDLE, PRESS_WAIT, PRESSED, LONG_HELD, RELEASE_WAIT; all outputs registered.
  - IDLE: if ksync=1 -> PRESS_WAIT, cnt=0.
  - PRESS_WAIT:
    - ksync=0 at any clk -> IDLE (bounce, no event).
    - On tick: cnt++; when cnt reaches DEBOUNCE_TICKS -> PRESSED, key_level<=1, key_press pulse next clk, hold=0.
  - PRESSED:
    - On tick, hold++ (saturating).
    - When hold reaches LONG_TICKS -> LONG_HELD with one-clk key_long pulse.
    - ksync=0 -> RELEASE_WAIT, cnt=0, long_done=0.
  - LONG_HELD: no further key_long; ksync=0 -> RELEASE_WAIT, cnt=0, long_done=1.
  - RELEASE_WAIT:
    - ksync=1 at any clk -> back to LONG_HELD if long_done else PRESSED; hold is preserved, not reset.
    - On tick while ksync=0: cnt++; at DEBOUNCE_TICKS -> IDLE, key_level<=0, key_release pulse.
    - key_level stays 1 throughout RELEASE_WAIT.
- Ticks only advance counters; state aborts (bounce) act on any clk edge.
- Counter width: clog2(max(DEBOUNCE_TICKS, LONG_TICKS)+1). Counters never wrap; hold saturates at LONG_TICKS.
- Keys are fully independent; simultaneous events on several keys produce simultaneous pulses.
- Event exclusivity:
  - key_press and key_release are never both 1 for the same key in one cycle.
  - key_long fires at most once between a key_press and the following key_release.
- Reset mid-press: everything returns to IDLE, no release pulse.
  - A key still held after reset release goes through PRESS_WAIT and produces a normal key_press.
- Effective press latency: 2 clk (sync) + DEBOUNCE_TICKS ticks (jitter up to 1 tick) + 1 clk.

Decomposition:
- Shared package key_pkg holds:
  - the FSM state enum (IDLE, PRESS_WAIT, PRESSED, LONG_HELD, RELEASE_WAIT);
  - the TICK_DIV and counter-width derivation functions.
- Sub-module key_debounce_fsm: one key's synchroniser, FSM and counters (inputs clk, nrst, key_n_i, tick; four event/level outputs).
- Instantiated N_KEYS times via generate; the tick generator lives in key_scan4.

Test Plan:
- Bench params for all scenarios: CLK_HZ=1000, TICK_HZ=100 (TICK_DIV=10), DEBOUNCE_TICKS=3, LONG_TICKS=10.
- Reset, key_n=4'b1111 for 200 clk -> all outputs 0; tick pulses every 10 clk, first at clk 10 after reset release.
- Clean press: key_n[0]=0 held -> exactly one key_press[0] pulse, 3-4 ticks after ksync rises; key_level[0]=1 from that cycle.
- Bounce: key_n[1] toggles 0/1 every 7 clk for 100 clk, then held 0 -> no key_press[1] during toggling; exactly one key_press[1] after the stable hold.
- Long press: hold key_n[2]=0 for 150 clk -> key_press[2] once, then key_long[2] once 10 ticks later. Release -> key_release[2] once after 3 ticks; key_level[2]=0.
- Release glitch: while key 3 is pressed, pulse key_n[3]=1 for 15 clk -> no key_release[3], no second key_press[3]; key_level[3] stays 1.
- Simultaneous keys and reset: press keys 0 and 3 on the same clk -> same-cycle key_press on both. Assert nrst=0 mid-hold -> outputs 0 immediately. Deassert with keys still held -> fresh key_press pulses after debounce, no key_release.
